// File: rtl/multi_cycle_control_if.sv
// Control bundle between the multi-cycle controller and its datapath.
// The controller takes the master side and the datapath takes the slave side.
interface multi_cycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_source;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source, state
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_source, state
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle MIPS subset (lw/sw/R-type/beq/addi/j).
// Outputs decode the state register; pc_en in BRANCH follows the zero flag.
module multi_cycle_control (
    input  logic                   clk,
    input  logic                   rst,
    multi_cycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d        = FETCH;
        bus.pc_en      = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 2'd0;
        bus.mem_to_reg = 2'd0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'd0;
        bus.alu_ctrl   = 3'b000;
        bus.pc_source  = 2'd0;
        case (state_q)
            FETCH: begin
                bus.ir_write  = 1'b1;
                bus.alu_src_b = 2'd1;
                bus.alu_ctrl  = 3'b010;
                bus.pc_en     = 1'b1;
                state_d       = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode decodes
                bus.alu_src_b = 2'd3;
                bus.alu_ctrl  = 3'b010;
                case (bus.opcode)
                    6'h23, 6'h2B: state_d = MEMADR;
                    6'h00:        state_d = EXEC;
                    6'h04:        state_d = BRANCH;
                    6'h08:        state_d = ADDIEX;
                    6'h02:        state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_ctrl  = 3'b010;
                state_d       = (bus.opcode == 6'h23) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                bus.iord = 1'b1;
                state_d  = MEMWB;
            end
            MEMWB: begin
                bus.mem_to_reg = 2'd1;
                bus.reg_write  = 1'b1;
            end
            MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = 1'b1;
            end
            EXEC: begin
                bus.alu_src_a = 1'b1;
                case (bus.funct)
                    6'h22:   bus.alu_ctrl = 3'b110;
                    6'h24:   bus.alu_ctrl = 3'b000;
                    6'h25:   bus.alu_ctrl = 3'b001;
                    6'h2A:   bus.alu_ctrl = 3'b111;
                    default: bus.alu_ctrl = 3'b010;
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                bus.reg_dst   = 2'd1;
                bus.reg_write = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.alu_ctrl  = 3'b110;
                bus.pc_source = 2'd1;
                bus.pc_en     = bus.zero;
            end
            ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'd2;
                bus.alu_ctrl  = 3'b010;
                state_d       = ADDIWB;
            end
            ADDIWB: begin
                bus.reg_write = 1'b1;
            end
            JUMP: begin
                bus.pc_source = 2'd2;
                bus.pc_en     = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    assign bus.state = state_q;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle expected state/controls are
// queued per instruction, then popped and compared on each falling edge.
module tb_multi_cycle_control;
    typedef struct packed {
        logic       pc_en, iord, mem_write, ir_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_source;
    } ctrl_t;

    typedef struct packed {
        logic [3:0] st;
        ctrl_t      c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_control_if bus();
    multi_cycle_control dut (.clk(clk), .rst(rst), .bus(bus));

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    // Reference control table, written straight from the state descriptions
    function automatic ctrl_t model(logic [3:0] st, logic [5:0] f, logic z);
        ctrl_t c;
        c = '0;
        case (st)
            4'd0:  begin c.pc_en = 1; c.ir_write = 1; c.alu_src_b = 2'd1; c.alu_ctrl = 3'b010; end
            4'd1:  begin c.alu_src_b = 2'd3; c.alu_ctrl = 3'b010; end
            4'd2:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_ctrl = 3'b010; end
            4'd3:  c.iord = 1;
            4'd4:  begin c.mem_to_reg = 2'd1; c.reg_write = 1; end
            4'd5:  begin c.iord = 1; c.mem_write = 1; end
            4'd6:  begin
                c.alu_src_a = 1;
                c.alu_ctrl = (f == 6'h22) ? 3'b110 : (f == 6'h24) ? 3'b000 :
                             (f == 6'h25) ? 3'b001 : (f == 6'h2A) ? 3'b111 : 3'b010;
            end
            4'd7:  begin c.reg_dst = 2'd1; c.reg_write = 1; end
            4'd8:  begin c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_source = 2'd1; c.pc_en = z; end
            4'd9:  begin c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_ctrl = 3'b010; end
            4'd10: c.reg_write = 1;
            4'd11: begin c.pc_source = 2'd2; c.pc_en = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic ctrl_t obs_ctrl();
        ctrl_t c;
        c.pc_en = bus.pc_en;          c.iord = bus.iord;
        c.mem_write = bus.mem_write;  c.ir_write = bus.ir_write;
        c.reg_dst = bus.reg_dst;      c.mem_to_reg = bus.mem_to_reg;
        c.reg_write = bus.reg_write;  c.alu_src_a = bus.alu_src_a;
        c.alu_src_b = bus.alu_src_b;  c.alu_ctrl = bus.alu_ctrl;
        c.pc_source = bus.pc_source;
        return c;
    endfunction

    task automatic check(string tag, logic [3:0] est, ctrl_t ec);
        ctrl_t oc;
        oc = obs_ctrl();
        total++;
        assert (bus.state === est) else begin
            bad++;
            $error("FAIL %s state obs=%0d exp=%0d", tag, bus.state, est);
        end
        total++;
        assert (oc === ec) else begin
            bad++;
            $error("FAIL %s ctrl st=%0d obs=%h exp=%h", tag, est, oc, ec);
        end
    endtask

    // seq holds the expected state codes, first state in the low nibble.
    // Opcode/funct are scrambled in states that must ignore them.
    task automatic run_instr(string tag, logic [5:0] op, logic [5:0] fn, logic z,
                             logic [23:0] seq, int n);
        exp_t e;
        bus.zero = z;
        for (int i = 0; i < n; i++)
            sb.push_back({seq[4*i +: 4], model(seq[4*i +: 4], fn, z)});
        for (int i = 0; i < n; i++) begin
            e = sb.pop_front();
            if (e.st inside {4'd0, 4'd1, 4'd2, 4'd6}) begin
                bus.opcode = op;
                bus.funct  = fn;
            end else begin
                bus.opcode = 6'($urandom);
                bus.funct  = 6'($urandom);
            end
            check(tag, e.st, e.c);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        bus.opcode = 6'h00;
        bus.funct  = 6'h00;
        bus.zero   = 1'b0;
        #3;
        check("reset_async", 4'd0, model(4'd0, 6'h0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        check("reset_held", 4'd0, model(4'd0, 6'h0, 1'b0));
        rst = 1'b0;

        run_instr("lw",      6'h23, 6'h00, 1'b0, 24'h43210, 5);
        run_instr("sub",     6'h00, 6'h22, 1'b0, 24'h7610,  4);
        run_instr("beq_z1",  6'h04, 6'h00, 1'b1, 24'h810,   3);
        run_instr("beq_z0",  6'h04, 6'h00, 1'b0, 24'h810,   3);
        run_instr("sw",      6'h2B, 6'h00, 1'b0, 24'h5210,  4);
        run_instr("unknown", 6'h3F, 6'h00, 1'b0, 24'h10,    2);
        run_instr("addi",    6'h08, 6'h00, 1'b0, 24'hA910,  4);
        run_instr("j",       6'h02, 6'h00, 1'b0, 24'hB10,   3);
        run_instr("add",     6'h00, 6'h20, 1'b0, 24'h7610,  4);
        run_instr("and",     6'h00, 6'h24, 1'b0, 24'h7610,  4);
        run_instr("or",      6'h00, 6'h25, 1'b0, 24'h7610,  4);
        run_instr("slt",     6'h00, 6'h2A, 1'b0, 24'h7610,  4);
        run_instr("rfunct",  6'h00, 6'h3F, 1'b0, 24'h7610,  4);

        // Abort a load in MEMRD with an asynchronous reset pulse
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 24'h210, 3);
        check("memrd", 4'd3, model(4'd3, 6'h0, 1'b0));
        #2 rst = 1'b1;
        #1 check("rst_mid", 4'd0, model(4'd0, 6'h0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", 4'd0, model(4'd0, 6'h0, 1'b0));
        rst = 1'b0;
        bus.opcode = 6'h3F;
        @(posedge clk);
        @(negedge clk);
        check("rst_resume", 4'd1, model(4'd1, 6'h0, 1'b0));
        @(posedge clk);
        @(negedge clk);
        check("final", 4'd0, model(4'd0, 6'h0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
